// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared defaults and helpers for the memory read-port arbiter.
//   - DEF_* constants : default parameter values for mem_rd_arbiter
//   - idx2onehot()    : index -> one-hot vector (supports up to 32 clients)
package mem_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 1;
    localparam int DEF_MAX_ADDR   = 2;
    localparam int DEF_BURST      = 2;

    // Callers truncate the result to their own client count.
    function automatic logic [31:0] idx2onehot(input logic [31:0] idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational rotating priority encoder.
//   Ports:
//     i_req   [NUM_REQ-1:0]  request vector
//     i_start [IDXW-1:0]     index searched first; search wraps upward
//     o_found                at least one request is set
//     o_idx   [IDXW-1:0]     first requesting index at or after i_start
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_start,
    output logic               o_found,
    output logic [IDXW-1:0]    o_idx
);

    int w_j;

    // Walk from the farthest position back to i_start so the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = (int'(i_start) + k) % NUM_REQ;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(w_j);
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter
//   Round-robin arbiter sharing one registered memory read port among
//   NUM_REQ clients, with a burst allowance of BURST consecutive grants.
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_req[NUM_REQ]        per-client request, held until granted
//     i_req_addr            packed addresses, client i at [i*ADDRSIZE +: ADDRSIZE]
//     o_gnt[NUM_REQ]        one-hot combinational grant
//     o_rsp_vld[NUM_REQ]    one-hot registered response valid (grant + 1 cycle)
//     o_rsp_data            shared response data (= i_mem_rd_data)
//     o_mem_rd_en/addr      memory read port controls
//     i_mem_rd_data         memory read data
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_ADDR   = DEF_MAX_ADDR,
    parameter int ADDRSIZE   = $clog2(MAX_ADDR),
    parameter int BURST      = DEF_BURST
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*ADDRSIZE-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]          o_gnt,
    output logic [NUM_REQ-1:0]          o_rsp_vld,
    output logic [DATA_WIDTH-1:0]       o_rsp_data,
    output logic                        o_mem_rd_en,
    output logic [ADDRSIZE-1:0]         o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]       i_mem_rd_data
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(BURST + 1);

    logic [IDXW-1:0]    r_owner;
    logic               r_owner_vld;
    logic [CW-1:0]      r_burst_cnt;
    logic [NUM_REQ-1:0] r_rsp_vld;

    logic [IDXW-1:0]    w_start;
    logic               w_found;
    logic [IDXW-1:0]    w_pick;
    logic               w_cont;
    logic               w_gnt_vld;
    logic [IDXW-1:0]    w_gnt_idx;

    // Search begins one past the owner so the owner itself is checked last.
    assign w_start = (r_owner == IDXW'(NUM_REQ - 1)) ? '0 : r_owner + IDXW'(1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .i_req   (i_req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_cont    = r_owner_vld && i_req[r_owner] && (r_burst_cnt < CW'(BURST));
    assign w_gnt_vld = !i_rst && (w_cont || w_found);
    assign w_gnt_idx = w_cont ? r_owner : w_pick;

    assign o_gnt         = w_gnt_vld ? NUM_REQ'(idx2onehot(32'(w_gnt_idx))) : '0;
    assign o_mem_rd_en   = w_gnt_vld;
    assign o_mem_rd_addr = w_gnt_vld ? i_req_addr[w_gnt_idx*ADDRSIZE +: ADDRSIZE] : '0;
    assign o_rsp_data    = i_mem_rd_data;

    // Masking with reset drops the response of a grant issued just before
    // reset rises; the register alone would still show it for that cycle.
    assign o_rsp_vld = i_rst ? '0 : r_rsp_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= IDXW'(NUM_REQ - 1);
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
            r_rsp_vld   <= '0;
        end else begin
            r_rsp_vld <= o_gnt;
            if (w_cont) begin
                r_burst_cnt <= r_burst_cnt + CW'(1);
            end else if (w_found) begin
                r_owner     <= w_pick;
                r_owner_vld <= 1'b1;
                r_burst_cnt <= CW'(1);
            end else begin
                // Owner index is kept as the rotation pointer.
                r_owner_vld <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
module tb_mem_rd_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MA = 16;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_vld;
    logic [DW-1:0]     rsp_data;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [DW-1:0]     mem_rd_data;

    // write port of the memory model
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     mem [MA];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_ADDR(MA), .ADDRSIZE(AW), .BURST(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_addr(req_addr),
        .o_gnt(gnt), .o_rsp_vld(rsp_vld), .o_rsp_data(rsp_data),
        .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
        .i_mem_rd_data(mem_rd_data)
    );

    // Dual-port memory: registered read returns the pre-write word.
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive shortly after the rising edge, sample on the falling edge
    task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR*AW-1:0] a);
        @(posedge clk);
        #1;
        rst = r; req = q; req_addr = a;
    endtask

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*AW-1:0] addr;
        logic [NR-1:0]    gnt;
        logic [NR-1:0]    rv;
        logic [DW-1:0]    data;
    } vec_t;

    vec_t tbl [15];

    initial begin
        for (int a = 0; a < MA; a++) mem[a] = DW'(a + 'h10);
        mem_rd_data = '0;
        rst = 1'b1; req = '1; req_addr = '0; we = 1'b0; waddr = '0; wdata = '0;

        tbl[0]  = '{4'b1111, 16'h3210, 4'b0001, 4'b0000, 8'h00}; // first grant -> client 0
        tbl[1]  = '{4'b0100, 16'h0500, 4'b0100, 4'b0001, 8'h10}; // single client 2, addr 5
        tbl[2]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0100, 8'h15};
        tbl[3]  = '{4'b0011, 16'h0021, 4'b0001, 4'b0000, 8'h00}; // contention 0,0,1,1,0,0
        tbl[4]  = '{4'b0011, 16'h0021, 4'b0001, 4'b0001, 8'h11};
        tbl[5]  = '{4'b0011, 16'h0021, 4'b0010, 4'b0001, 8'h11};
        tbl[6]  = '{4'b0011, 16'h0021, 4'b0010, 4'b0010, 8'h12};
        tbl[7]  = '{4'b0011, 16'h0021, 4'b0001, 4'b0010, 8'h12};
        tbl[8]  = '{4'b0011, 16'h0021, 4'b0001, 4'b0001, 8'h11};
        tbl[9]  = '{4'b1000, 16'h9000, 4'b1000, 4'b0001, 8'h11}; // sole requester 5 cycles
        tbl[10] = '{4'b1000, 16'h9000, 4'b1000, 4'b1000, 8'h19};
        tbl[11] = '{4'b1000, 16'h9000, 4'b1000, 4'b1000, 8'h19};
        tbl[12] = '{4'b1000, 16'h9000, 4'b1000, 4'b1000, 8'h19};
        tbl[13] = '{4'b1000, 16'h9000, 4'b1000, 4'b1000, 8'h19};
        tbl[14] = '{4'b0000, 16'h0000, 4'b0000, 4'b1000, 8'h19};

        // reset held 3 cycles with all clients requesting
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'b1111, 16'h3210);
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rd_en", 32'(mem_rd_en), 0);
            chk("rst_rsp_vld", 32'(rsp_vld), 0);
        end

        for (int v = 0; v < 15; v++) begin
            drive(1'b0, tbl[v].req, tbl[v].addr);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
            chk($sformatf("v%0d_rd_en", v), 32'(mem_rd_en), 32'(|tbl[v].gnt));
            chk($sformatf("v%0d_rsp_vld", v), 32'(rsp_vld), 32'(tbl[v].rv));
            if (tbl[v].rv != '0)
                chk($sformatf("v%0d_rsp_data", v), 32'(rsp_data), 32'(tbl[v].data));
        end

        // read and write to addr 7 in the same cycle: old word returned
        drive(1'b0, 4'b0010, 16'h0070);
        we = 1'b1; waddr = 4'd7; wdata = 8'hAA;
        @(negedge clk);
        chk("rdw_gnt", 32'(gnt), 32'b0010);
        chk("rdw_addr", 32'(mem_rd_addr), 7);
        drive(1'b0, 4'b0000, 16'h0000);
        we = 1'b0;
        @(negedge clk);
        chk("rdw_rsp_vld", 32'(rsp_vld), 32'b0010);
        chk("rdw_old_data", 32'(rsp_data), 32'h17);
        drive(1'b0, 4'b0010, 16'h0070);
        @(negedge clk);
        chk("reread_gnt", 32'(gnt), 32'b0010);
        drive(1'b0, 4'b0000, 16'h0000);
        @(negedge clk);
        chk("reread_data", 32'(rsp_data), 32'hAA);

        // reset right after a grant drops its response
        drive(1'b0, 4'b0001, 16'h0003);
        @(negedge clk);
        chk("pre_rst_gnt", 32'(gnt), 32'b0001);
        drive(1'b1, 4'b0001, 16'h0003);
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_rsp_vld", 32'(rsp_vld), 0);
        drive(1'b1, 4'b1111, 16'h3210);
        @(negedge clk);
        chk("mid_rst_rsp_vld2", 32'(rsp_vld), 0);
        drive(1'b0, 4'b1111, 16'h3214);
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        chk("post_rst_addr", 32'(mem_rd_addr), 4);
        drive(1'b0, 4'b0000, 16'h0000);
        @(negedge clk);
        chk("post_rst_rsp_vld", 32'(rsp_vld), 32'b0001);
        chk("post_rst_data", 32'(rsp_data), 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
